// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame receiver: FSM state encoding and checksum width.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_e;

  localparam int CHK_W = 8;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file, one synchronous write port, one asynchronous read port.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser (SOF, LEN, payload, checksum) that buffers the payload and releases it
// on a valid/ready stream only once the checksum has been verified.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int          TIMEOUT_CLKS = 104160,
  localparam int         LW           = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [LW-1:0] frame_len,
  output logic          busy,
  output logic          chk_err,
  output logic          len_err,
  output logic          timeout_err,
  output logic          ovr_err
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  // Expiry is detected one cycle early so the registered pulse lands
  // exactly TIMEOUT_CLKS cycles after the last accepted byte.
  localparam logic [TW-1:0] EXPIRE = TW'(TIMEOUT_CLKS - 2);

  state_e           state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    widx_q, widx_d;
  logic [LW-1:0]    ridx_q, ridx_d;
  logic [CHK_W-1:0] sum_q, sum_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             chk_err_q, chk_err_d;
  logic             len_err_q, len_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             ovr_err_q, ovr_err_d;

  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             in_frame;
  logic             expire;
  logic             drain;
  logic             last;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (widx_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (ridx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign expire   = in_frame && !rx_done && (cnt_q == EXPIRE);
  assign drain    = (state_q == ST_DRAIN);
  assign last     = (ridx_q == len_q - LW'(1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    widx_d        = widx_q;
    ridx_d        = ridx_q;
    sum_d         = sum_q;
    buf_we        = 1'b0;
    chk_err_d     = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    ovr_err_d     = 1'b0;
    cnt_d         = (in_frame && !rx_done && !expire) ? cnt_q + TW'(1) : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_done && rx_data == SOF) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (rx_done) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d   = rx_data[LW-1:0];
            sum_d   = rx_data;
            widx_d  = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (rx_done) begin
          buf_we = 1'b1;
          widx_d = widx_q + LW'(1);
          sum_d  = sum_q + rx_data;
          if (widx_q == len_q - LW'(1)) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (rx_done) begin
          if (rx_data == sum_q) begin
            ridx_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            chk_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // The receiver cannot be stalled, so bytes arriving while draining are lost.
        ovr_err_d = rx_done;
        if (m_ready) begin
          ridx_d = ridx_q + LW'(1);
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      widx_q        <= '0;
      ridx_q        <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      chk_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      ovr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      widx_q        <= widx_d;
      ridx_q        <= ridx_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      chk_err_q     <= chk_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
      ovr_err_q     <= ovr_err_d;
    end
  end

  assign m_valid     = drain;
  assign m_data      = drain ? buf_rdata : 8'd0;
  assign m_last      = drain && last;
  assign frame_len   = len_q;
  assign busy        = (state_q != ST_IDLE);
  assign chk_err     = chk_err_q;
  assign len_err     = len_err_q;
  assign timeout_err = timeout_err_q;
  assign ovr_err     = ovr_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: framing, checksum, length, timeout, backpressure, overrun, reset.
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_last;
  logic [LW-1:0] frame_len;
  logic          busy;
  logic          chk_err;
  logic          len_err;
  logic          timeout_err;
  logic          ovr_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] pl [16];

  uart_frame_rx #(
    .MAX_LEN      (MAX_LEN),
    .SOF          (8'hA5),
    .TIMEOUT_CLKS (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .frame_len   (frame_len),
    .busy        (busy),
    .chk_err     (chk_err),
    .len_err     (len_err),
    .timeout_err (timeout_err),
    .ovr_err     (ovr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one byte for exactly one cycle; returns at the negedge after it was consumed.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(pl[i]);
    send_byte(chk);
  endtask

  // Streams out n bytes with m_ready high, expecting pl[0..n-1] from the first cycle.
  task automatic drain_frame(input int n, input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if ({m_valid, m_last, m_data, frame_len} !== {1'b1, (i == n - 1), pl[i], LW'(n)}) begin
        n_err++;
        $display("FAIL %s byte%0d: got v=%b l=%b d=%h len=%0d, want v=1 l=%b d=%h len=%0d",
                 tag, i, m_valid, m_last, m_data, frame_len, (i == n - 1), pl[i], n);
      end
      n_cmp++;
      if ({chk_err, len_err, timeout_err, ovr_err} !== 4'b0000) begin
        n_err++;
        $display("FAIL %s err_during_drain%0d: got %b want 0000", tag, i,
                 {chk_err, len_err, timeout_err, ovr_err});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({m_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s end_of_drain: got valid=%b busy=%b want 0 0", tag, m_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_valid, m_last, m_data, frame_len, busy, chk_err, len_err, timeout_err, ovr_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h len=%0d busy=%b errs=%b want all 0",
               m_valid, m_last, m_data, frame_len, busy, {chk_err, len_err, timeout_err, ovr_err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_valid_frame();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    m_ready = 1'b1;
    send_frame(3, 8'h69);
    drain_frame(3, "valid");
  endtask

  task automatic test_bad_checksum();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, 8'h6A);
    n_cmp++;
    if ({chk_err, m_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL badchk_pulse: got chk=%b v=%b busy=%b want 1 0 0", chk_err, m_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({chk_err, m_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL badchk_one_cycle: got chk=%b v=%b want 0 0", chk_err, m_valid);
    end
    send_frame(3, 8'h69);
    drain_frame(3, "after_badchk");
  endtask

  task automatic test_bad_length();
    logic [7:0] bad_len [2];
    bad_len[0] = 8'h00;
    bad_len[1] = 8'h11;
    for (int k = 0; k < 2; k++) begin
      send_byte(8'hA5);
      send_byte(bad_len[k]);
      n_cmp++;
      if ({len_err, busy} !== 2'b10) begin
        n_err++;
        $display("FAIL badlen_%h: got len_err=%b busy=%b want 1 0", bad_len[k], len_err, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (len_err !== 1'b0) begin
        n_err++;
        $display("FAIL badlen_%h_one_cycle: got %b want 0", bad_len[k], len_err);
      end
    end
    pl[0] = 8'hA5;
    send_frame(1, 8'hA6);
    drain_frame(1, "sof_in_payload");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    for (int k = 1; k < 20; k++) begin
      n_cmp++;
      if ({timeout_err, busy} !== 2'b01) begin
        n_err++;
        $display("FAIL timeout_gap%0d: got to=%b busy=%b want 0 1", k, timeout_err, busy);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({timeout_err, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL timeout_pulse: got to=%b busy=%b want 1 0", timeout_err, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_one_cycle: got %b want 0", timeout_err);
    end
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (18) @(negedge clk);
    send_byte(8'h22);
    n_cmp++;
    if ({timeout_err, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_rescued: got to=%b busy=%b want 0 1", timeout_err, busy);
    end
    send_byte(8'h35);
    drain_frame(2, "late_byte");
  endtask

  task automatic test_backpressure_overrun();
    int idx;
    logic ph;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    m_ready = 1'b0;
    send_frame(4, 8'h0E);
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({m_valid, m_last, m_data, frame_len} !== {1'b1, 1'b0, 8'h01, LW'(4)}) begin
        n_err++;
        $display("FAIL stall%0d: got v=%b l=%b d=%h len=%0d want v=1 l=0 d=01 len=4",
                 c, m_valid, m_last, m_data, frame_len);
      end
      if (c == 5 || c == 6) begin
        n_cmp++;
        if (ovr_err !== (c == 5)) begin
          n_err++;
          $display("FAIL ovr_stall_c%0d: got %b want %b", c, ovr_err, (c == 5));
        end
      end
      if (c == 4) begin
        rx_data = 8'h77;
        rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
    end
    idx = 0;
    ph  = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      m_ready = ph;
      n_cmp++;
      if ({m_valid, m_last, m_data} !== {1'b1, (idx == 3), pl[idx]}) begin
        n_err++;
        $display("FAIL alt_ready_c%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 c, m_valid, m_last, m_data, (idx == 3), pl[idx]);
      end
      if (ph && idx == 3) begin
        rx_data = 8'h77;
        rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
      if (ph) idx++;
      ph = !ph;
    end
    n_cmp++;
    if ({idx == 4, m_valid, busy, ovr_err} !== 4'b1001) begin
      n_err++;
      $display("FAIL ovr_final: got done=%b v=%b busy=%b ovr=%b want 1 0 0 1",
               (idx == 4), m_valid, busy, ovr_err);
    end
    @(negedge clk);
    n_cmp++;
    if (ovr_err !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_one_cycle: got %b want 0", ovr_err);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_noise_reset();
    logic [7:0] noise [3];
    noise[0] = 8'h00; noise[1] = 8'hFF; noise[2] = 8'h5A;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_byte(noise[k]);
      n_cmp++;
      if ({busy, chk_err, len_err, timeout_err, ovr_err} !== 5'b00000) begin
        n_err++;
        $display("FAIL noise_%h: got busy=%b errs=%b want 0 0000", noise[k], busy,
                 {chk_err, len_err, timeout_err, ovr_err});
      end
    end
    pl[0] = 8'hC3; pl[1] = 8'h3C;
    send_frame(2, 8'h01);
    drain_frame(2, "after_noise");
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_payload_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_valid, m_last, m_data, frame_len, busy, chk_err, len_err, timeout_err, ovr_err} !== '0) begin
      n_err++;
      $display("FAIL midframe_reset: got v=%b d=%h len=%0d busy=%b errs=%b want all 0",
               m_valid, m_data, frame_len, busy, {chk_err, len_err, timeout_err, ovr_err});
    end
    rst = 1'b0;
    @(negedge clk);
    pl[0] = 8'h5A;
    send_frame(1, 8'h5B);
    drain_frame(1, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) pl[i] = 8'(i * 8'h11);
    m_ready = 1'b1;
    send_frame(16, 8'h08);
    drain_frame(16, "max_len");
    pl[0] = 8'h7E;
    send_frame(1, 8'h7F);
    drain_frame(1, "back_to_back");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_backpressure_overrun();
    test_noise_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
